sat_result_reporter: RTL and testbench

Downstream stage of the brute-force satisfiability sweep. It consumes the candidate vector and the evaluator's single-bit verdict on every sweep step, then:
- captures the first satisfying vector (the witness) and counts all satisfying vectors;
- at end of sweep, reports the result on LEDs, blinking the witness out serially so it is readable by eye.

It replaces the sticky one-bit latch that currently drives the "found" LED.

---
 rtl/sat_result_reporter_pkg.sv | 10 +
 rtl/sat_result_reporter_blink_serializer.sv | 50 +++++
 rtl/sat_result_reporter.sv | 59 +++++
 tb/tb_sat_result_reporter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/sat_result_reporter_pkg.sv
// sat_result_reporter_pkg: shared state encoding and blink slot phase constants.
package sat_result_reporter_pkg;
  typedef enum logic [1:0] {SCAN, REPORT, HALT} state_t;
  function automatic int quarter_len(input int slot_log2);
    return 1 << (slot_log2 - 2);
  endfunction
  function automatic int three_quarter_len(input int slot_log2);
    return 3 * quarter_len(slot_log2);
  endfunction
endpackage

// File: rtl/sat_result_reporter_blink_serializer.sv
// sat_result_reporter_blink_serializer: blinks the witness MSB first, one slot per bit plus a blank slot.
module sat_result_reporter_blink_serializer
  import sat_result_reporter_pkg::*;
#(
  parameter int BITS = 3,
  parameter int SLOT_LOG2 = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          run,
  input  logic [BITS:0] witness,
  output logic          led_out
);
  localparam int IW = $clog2(BITS + 2);
  localparam logic [SLOT_LOG2-1:0] Q = SLOT_LOG2'(quarter_len(SLOT_LOG2));
  localparam logic [SLOT_LOG2-1:0] TQ = SLOT_LOG2'(three_quarter_len(SLOT_LOG2));
  logic [BITS:0] wit, sh;
  logic [IW-1:0] idx;
  logic [SLOT_LOG2-1:0] phase;
  logic blank, slot_end, lit;
  always_comb begin
    blank = idx == IW'(BITS + 1);
    slot_end = &phase;
    lit = !blank && (phase < (sh[BITS] ? TQ : Q));
  end
  // Load emits slot 0 phase 0 directly, so counters start one position ahead of led_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      wit <= '0;
      sh <= '0;
      idx <= '0;
      phase <= '0;
      led_out <= 1'b0;
    end else if (load) begin
      wit <= witness;
      sh <= witness;
      idx <= '0;
      phase <= SLOT_LOG2'(1);
      led_out <= 1'b1;
    end else if (run) begin
      led_out <= lit;
      phase <= phase + SLOT_LOG2'(1);
      if (slot_end) begin
        idx <= blank ? '0 : idx + IW'(1);
        sh <= blank ? wit : {sh[BITS-1:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/sat_result_reporter.sv
// sat_result_reporter: captures the first satisfying vector, counts hits, and reports the sweep result on LEDs.
module sat_result_reporter
  import sat_result_reporter_pkg::*;
#(
  parameter int BITS = 3,
  parameter int SLOT_LOG2 = 22
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step,
  input  logic [BITS:0]   vec,
  input  logic            hit,
  input  logic            last,
  output logic [BITS+1:0] count,
  output logic [BITS:0]   witness,
  output logic            found,
  output logic            done,
  output logic            led_out,
  output logic            led_unsat
);
  state_t state;
  logic take, found_d;
  logic [BITS:0] wit_d;
  always_comb begin
    take = state == SCAN && step;
    found_d = found || hit;
    wit_d = (!found && hit) ? vec : witness;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SCAN;
      count <= '0;
      witness <= '0;
      found <= 1'b0;
      done <= 1'b0;
      led_unsat <= 1'b0;
    end else if (take) begin
      if (hit) begin
        count <= count + (BITS+2)'(1);
        witness <= wit_d;
        found <= 1'b1;
      end
      if (last) begin
        state <= found_d ? REPORT : HALT;
        done <= 1'b1;
        led_unsat <= !found_d;
      end
    end
  end
  // The serializer needs this step's capture, so it loads from the next-witness value.
  sat_result_reporter_blink_serializer #(.BITS(BITS), .SLOT_LOG2(SLOT_LOG2)) u_blink (
    .clk(clk),
    .rst(rst),
    .load(take && last && found_d),
    .run(state == REPORT),
    .witness(wit_d),
    .led_out(led_out)
  );
endmodule

// File: tb/tb_sat_result_reporter.sv
// tb_sat_result_reporter: scoreboard bench with a per-sweep result model and an LED frame monitor.
module tb_sat_result_reporter;
  localparam int BITS = 3;
  localparam int SLOT_LOG2 = 2;
  localparam int S = 1 << SLOT_LOG2;
  localparam int FRAME = (BITS + 2) * S;
  typedef struct {
    logic [BITS+1:0] cnt;
    logic [BITS:0] wit;
    logic fnd;
    logic unsat;
  } exp_t;
  logic clk = 0, rst = 1, step = 0, hit = 0, last = 0;
  logic [BITS:0] vec = '0;
  logic [BITS+1:0] count;
  logic [BITS:0] witness;
  logic found, done, led_out, led_unsat;
  int vectors = 0, miscompares = 0;
  exp_t sb[$];
  bit mon_busy = 0;
  sat_result_reporter #(.BITS(BITS), .SLOT_LOG2(SLOT_LOG2)) dut (
    .clk(clk), .rst(rst), .step(step), .vec(vec), .hit(hit), .last(last),
    .count(count), .witness(witness), .found(found), .done(done),
    .led_out(led_out), .led_unsat(led_unsat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic model_led(input logic [BITS:0] w, input int t);
    int slot = (t % FRAME) / S;
    int ph = t % S;
    if (slot > BITS) return 1'b0;
    return ph < (w[BITS-slot] ? 3 * S / 4 : S / 4);
  endfunction
  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("reset_outputs", {count, witness, found, done, led_out, led_unsat}, '0);
  endtask
  task automatic sweep(input logic [15:0] hm, input bit gaps);
    exp_t e;
    e.cnt = '0;
    e.wit = '0;
    e.fnd = 0;
    for (int i = 0; i < 16; i++) if (hm[i]) begin
      if (!e.fnd) e.wit = (BITS+1)'(i);
      e.fnd = 1;
      e.cnt++;
    end
    e.unsat = !e.fnd;
    for (int i = 0; i < 16; i++) begin
      step = 1; vec = (BITS+1)'(i); hit = hm[i]; last = i == 15;
      if (last) sb.push_back(e);
      @(posedge clk); #1 step = 0; hit = 0; last = 0;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    repeat (FRAME * 2 + 5) begin @(posedge clk); #1; end
  endtask
  initial begin : monitor
    exp_t e;
    logic prev_done = 0;
    forever begin
      @(negedge clk);
      if (done && !prev_done) begin
        mon_busy = 1;
        if (sb.size() == 0) chk("unexpected_done", 32'(done), 32'(0));
        else begin
          e = sb.pop_front();
          chk("count", 32'(count), 32'(e.cnt));
          chk("witness", 32'(witness), 32'(e.wit));
          chk("found", 32'(found), 32'(e.fnd));
          chk("led_unsat", 32'(led_unsat), 32'(e.unsat));
          for (int t = 0; t < 2 * FRAME; t++) begin
            if (t > 0) @(negedge clk);
            chk($sformatf("led_out[t=%0d]", t), 32'(led_out), 32'(e.fnd ? model_led(e.wit, t) : 1'b0));
          end
        end
        mon_busy = 0;
      end
      prev_done = done;
    end
  end
  initial begin : stimulus
    int budget;
    do_reset();
    sweep(16'h8080, 0);
    for (int i = 0; i < 4; i++) begin
      step = 1; vec = (BITS+1)'($urandom); hit = 1; last = 1'($urandom);
      @(posedge clk); #1 step = 0; hit = 0; last = 0;
    end
    chk("frozen_count", 32'(count), 32'd2);
    chk("frozen_witness", 32'(witness), 32'd7);
    repeat (7) begin @(posedge clk); #1; end
    do_reset();
    sweep(16'h0000, 0);
    do_reset();
    sweep(16'h8000, 0);
    do_reset();
    sweep(16'hffff, 0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step = 1; vec = (BITS+1)'(i); hit = i == 3;
      @(posedge clk); #1 step = 0; hit = 0;
    end
    chk("mid_sweep_count", 32'(count), 32'd1);
    chk("mid_sweep_witness", 32'(witness), 32'd3);
    do_reset();
    sweep(16'h0200, 0);
    for (int r = 0; r < 6; r++) begin
      do_reset();
      sweep(16'($urandom & $urandom), 1);
    end
    do_reset();
    budget = 0;
    while ((sb.size() != 0 || mon_busy) && budget < 300) begin @(posedge clk); budget++; end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
